// File: rtl/tqvp_affinex_stream.sv
// Streaming affine transform x' = a*x+b*y+tx, y' = d*x+e*y+ty between two point FIFOs, one shared multiplier.
// Pop-to-result 6 cycles, 1 point / 7 cycles; engine waits for output space, host pushes into a full input FIFO are dropped.

module tqvp_affinex_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [W-1:0]           dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i != pop_i) count_q <= push_i ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
endmodule

module tqvp_affinex_stream #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_WRITE} state_t;

  state_t                   state_q;
  logic [1:0]               stage_q;
  logic signed [WIDTH-1:0]  a_q, b_q, d_q, e_q, tx_q, ty_q, x_q, y_q, sx_q, sy_q;
  logic signed [PW-1:0]     p_q [4];
  logic                     en_q, sat_q, irq_en_q, done_q, push_ovf_q, arith_ovf_q;

  logic                     wr_en, rd_en, ctrl_wr, stat_wr, push_wr, flush, start, busy;
  logic                     in_push, in_full, in_empty, out_push, out_pop, out_full, out_empty;
  logic [PW-1:0]            in_dat, out_dat;
  logic [CW-1:0]            in_count, out_count;
  logic signed [WIDTH-1:0]  op_c, op_v, pop_x, pop_y;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     sum_x, sum_y, res_x, res_y;
  logic [WIDTH:0]           fx, fy;
  logic                     unused_ok;

  assign wr_en   = (data_write_n != 2'b11);
  assign rd_en   = (data_read_n != 2'b11);
  assign ctrl_wr = wr_en && (address == 6'h00);
  assign stat_wr = wr_en && (address == 6'h04);
  assign push_wr = wr_en && (address == 6'h20);
  assign flush   = ctrl_wr && data_in[3];
  assign busy    = (state_q != S_IDLE);

  // Fullness is sampled before the engine's same-cycle pop, so a push into a full FIFO is always dropped.
  assign in_push  = push_wr && !in_full;
  assign start    = (state_q == S_IDLE) && en_q && !in_empty && !out_full && !flush;
  assign out_push = (state_q == S_WRITE) && !flush;
  assign out_pop  = rd_en && (address == 6'h24) && !out_empty;

  tqvp_affinex_fifo #(.W(PW), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .rst_n(rst_n), .clr_i(flush), .push_i(in_push),
    .dat_i({data_in[16 +: WIDTH], data_in[WIDTH-1:0]}), .pop_i(start),
    .dat_o(in_dat), .count_o(in_count), .full_o(in_full), .empty_o(in_empty)
  );

  tqvp_affinex_fifo #(.W(PW), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .rst_n(rst_n), .clr_i(flush), .push_i(out_push),
    .dat_i({sy_q, sx_q}), .pop_i(out_pop),
    .dat_o(out_dat), .count_o(out_count), .full_o(out_full), .empty_o(out_empty)
  );

  always_comb begin
    op_c = a_q;
    op_v = x_q;
    case (stage_q)
      2'd1:    begin op_c = b_q; op_v = y_q; end
      2'd2:    begin op_c = d_q; op_v = x_q; end
      2'd3:    begin op_c = e_q; op_v = y_q; end
      default: ;
    endcase
  end

  assign prod = PW'(op_c) * PW'(op_v);

  // Shift the summed products once so rounding matches a single wide accumulate.
  assign sum_x = (SW'(p_q[0]) + SW'(p_q[1])) >>> FRAC;
  assign sum_y = (SW'(p_q[2]) + SW'(p_q[3])) >>> FRAC;
  assign res_x = sum_x + SW'(tx_q);
  assign res_y = sum_y + SW'(ty_q);

  function automatic logic [WIDTH:0] fit(input logic signed [SW-1:0] v, input logic sat);
    logic             ovf;
    logic [WIDTH-1:0] r;
    ovf = !((&v[SW-1:WIDTH-1]) || !(|v[SW-1:WIDTH-1]));
    r   = v[WIDTH-1:0];
    if (sat && ovf) r = v[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return {ovf, r};
  endfunction

  assign fx = fit(res_x, sat_q);
  assign fy = fit(res_y, sat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      stage_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          x_q     <= in_dat[WIDTH-1:0];
          y_q     <= in_dat[PW-1:WIDTH];
          stage_q <= '0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          p_q[stage_q] <= prod;
          stage_q      <= stage_q + 2'd1;
          if (stage_q == 2'd3) state_q <= S_SUM;
        end
        S_SUM: begin
          sx_q    <= fx[WIDTH-1:0];
          sy_q    <= fy[WIDTH-1:0];
          state_q <= S_WRITE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {en_q, sat_q, irq_en_q, done_q, push_ovf_q, arith_ovf_q} <= '0;
      {a_q, b_q, d_q, e_q, tx_q, ty_q} <= '0;
    end else begin
      if (ctrl_wr) {irq_en_q, sat_q, en_q} <= data_in[2:0];
      if (wr_en) begin
        case (address)
          6'h08:   a_q  <= data_in[WIDTH-1:0];
          6'h0C:   b_q  <= data_in[WIDTH-1:0];
          6'h10:   d_q  <= data_in[WIDTH-1:0];
          6'h14:   e_q  <= data_in[WIDTH-1:0];
          6'h18:   tx_q <= data_in[WIDTH-1:0];
          6'h1C:   ty_q <= data_in[WIDTH-1:0];
          default: ;
        endcase
      end
      if (flush)                          done_q <= 1'b0;
      else if (out_push && in_empty)      done_q <= 1'b1;
      else if (stat_wr && data_in[3])     done_q <= 1'b0;
      if (push_wr && in_full)             push_ovf_q <= 1'b1;
      else if (stat_wr && data_in[4])     push_ovf_q <= 1'b0;
      if (state_q == S_SUM && !flush && (fx[WIDTH] || fy[WIDTH])) arith_ovf_q <= 1'b1;
      else if (stat_wr && data_in[5])     arith_ovf_q <= 1'b0;
    end
  end

  assign pop_x = out_dat[WIDTH-1:0];
  assign pop_y = out_dat[PW-1:WIDTH];

  always_comb begin
    data_out = '0;
    case (address)
      6'h00: data_out = {29'd0, irq_en_q, sat_q, en_q};
      6'h04: data_out = {16'd0, 4'(out_count), 4'(in_count), 2'd0,
                         arith_ovf_q, push_ovf_q, done_q, out_empty, in_full, busy};
      6'h08: data_out = 32'(a_q);
      6'h0C: data_out = 32'(b_q);
      6'h10: data_out = 32'(d_q);
      6'h14: data_out = 32'(e_q);
      6'h18: data_out = 32'(tx_q);
      6'h1C: data_out = 32'(ty_q);
      6'h24: if (!out_empty) data_out = {16'(pop_y), 16'(pop_x)};
      default: ;
    endcase
  end

  assign uo_out         = {5'b0, done_q, busy, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_en_q & done_q;
  assign unused_ok      = &{1'b0, ui_in, data_in};
endmodule

// File: tb/tb_tqvp_affinex_stream.sv
// Directed bench for tqvp_affinex_stream: register map, latency, saturation, FIFO limits, interrupt, flush, reset.
module tb_tqvp_affinex_stream;
  localparam logic [5:0] CTRL = 6'h00, STAT = 6'h04, RA = 6'h08, RB = 6'h0C, RD = 6'h10;
  localparam logic [5:0] RE = 6'h14, RTX = 6'h18, RTY = 6'h1C, PUSH = 6'h20, POP = 6'h24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in, uo_out;
  logic [5:0]  address;
  logic [31:0] data_in, data_out, r;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;
  int          n_cmp = 0;
  int          n_err = 0;

  tqvp_affinex_stream dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write_n = 2'b10;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; data_read_n = 2'b10;
    #1 d = data_out;
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1 d = data_out;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ui_in = '0; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    cyc(3);
    peek(STAT, r);  chk("reset_status", r, 32'h0000_0004);
    chk("reset_uo_out", 32'(uo_out), 32'h0);
    chk("reset_irq", 32'(user_interrupt), 32'h0);
    chk("data_ready", 32'(data_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Identity plus offset, with exact latency
    wr(RA, 32'h100); wr(RE, 32'h100); wr(RTX, 32'd5); wr(RTY, 32'hFFFF_FFFD);
    peek(RTY, r);   chk("ty_sext", r, 32'hFFFF_FFFD);
    wr(PUSH, 32'h0014_000A);
    peek(STAT, r);  chk("one_queued", r, 32'h0000_0104);
    wr(CTRL, 32'h1);
    cyc(1); peek(STAT, r); chk("popped_busy", r, 32'h0000_0005);
    cyc(5); peek(STAT, r); chk("lat_k5", r, 32'h0000_0005);
    cyc(1); peek(STAT, r); chk("lat_k6", r, 32'h0000_1008);
    chk("uo_done", 32'(uo_out), 32'h04);
    rd(POP, r);     chk("identity_pop", r, 32'h0011_000F);
    peek(STAT, r);  chk("after_pop", r, 32'h0000_000C);
    wr(STAT, 32'h8);
    peek(STAT, r);  chk("done_w1c", r, 32'h0000_0004);
    rd(POP, r);     chk("pop_empty", r, 32'h0);
    peek(STAT, r);  chk("pop_empty_noflag", r, 32'h0000_0004);
    wr(6'h3C, 32'hFFFF_FFFF);
    peek(6'h3C, r); chk("unmapped", r, 32'h0);

    // 90 degree rotation
    wr(RA, 32'h0); wr(RE, 32'h0); wr(RB, 32'hFF00); wr(RD, 32'h100); wr(RTX, 32'h0); wr(RTY, 32'h0);
    wr(PUSH, 32'h0004_0003);
    cyc(10);
    rd(POP, r);     chk("rotate_pop", r, 32'h0003_FFFC);
    wr(STAT, 32'h8);

    // Saturate, then truncate
    wr(RB, 32'h0); wr(RD, 32'h0); wr(RA, 32'h7FFF);
    wr(CTRL, 32'h3);
    wr(PUSH, 32'h0000_7FFF);
    cyc(10);
    rd(POP, r);     chk("sat_pop", r, 32'h0000_7FFF);
    peek(STAT, r);  chk("sat_arith_ovf", r, 32'h0000_002C);
    wr(STAT, 32'h38);
    wr(CTRL, 32'h1);
    wr(PUSH, 32'h0000_7FFF);
    cyc(10);
    rd(POP, r);     chk("trunc_pop", r, 32'h0000_FF00);
    peek(STAT, r);  chk("trunc_arith_ovf", r, 32'h0000_002C);
    wr(STAT, 32'h28);
    peek(STAT, r);  chk("arith_w1c", r, 32'h0000_0004);

    // FIFO full and ordered drain
    wr(CTRL, 32'h0); wr(RA, 32'h100); wr(RE, 32'h100);
    for (int i = 0; i < 5; i++) wr(PUSH, {16'(2 * i + 2), 16'(2 * i + 1)});
    peek(STAT, r);  chk("in_full_ovf", r, 32'h0000_0416);
    wr(CTRL, 32'h1);
    cyc(27); peek(STAT, r); chk("drain_27", r, 32'h0000_3011);
    cyc(1);  peek(STAT, r); chk("drain_28", r, 32'h0000_4018);
    for (int i = 0; i < 4; i++) begin
      rd(POP, r);   chk("fifo_order", r, {16'(2 * i + 2), 16'(2 * i + 1)});
    end
    rd(POP, r);     chk("fifth_absent", r, 32'h0);
    peek(STAT, r);  chk("drained", r, 32'h0000_001C);
    wr(STAT, 32'h18);

    // Interrupt on the last WRITE, W1C, then flush mid-MUL
    wr(CTRL, 32'h5);
    wr(PUSH, 32'h0002_0001); wr(PUSH, 32'h0004_0003);
    cyc(12); chk("irq_before", 32'(user_interrupt), 32'h0);
    cyc(1);  chk("irq_after", 32'(user_interrupt), 32'h1);
    chk("uo_irq", 32'(uo_out), 32'h04);
    wr(STAT, 32'h8);
    chk("irq_cleared", 32'(user_interrupt), 32'h0);
    wr(PUSH, 32'h0006_0005);
    cyc(1);  chk("uo_busy", 32'(uo_out), 32'h02);
    peek(STAT, r);  chk("pre_flush", r, 32'h0000_2001);
    wr(CTRL, 32'hD);
    peek(STAT, r);  chk("flushed", r, 32'h0000_0004);
    cyc(10); peek(STAT, r); chk("flush_no_output", r, 32'h0000_0004);
    peek(CTRL, r);  chk("ctrl_after_flush", r, 32'h5);

    // Asynchronous reset in the middle of a point
    wr(PUSH, 32'h0000_0001);
    cyc(2);
    #2 rst_n = 1'b0;
    peek(STAT, r);  chk("arst_status", r, 32'h0000_0004);
    peek(CTRL, r);  chk("arst_ctrl", r, 32'h0);
    peek(RA, r);    chk("arst_coef", r, 32'h0);
    chk("arst_uo", 32'(uo_out), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
